// File: rtl/id_stage_pipe.sv
// id_stage_pipe: pipelined MIPS instruction-decode stage.
//   Holds the architectural register file (write-back port with same-cycle
//   bypass), decodes destination / write enable / immediate, detects load-use
//   hazards and registers the result into an ID/EX register with a
//   valid/ready handshake.
// Ports:
//   CLK, RST (async, active-low)
//   InValid/InReady/Ins       - upstream instruction handshake
//   Flush                     - drop ID/EX contents, block capture
//   WbEn/WbAdr/WbData         - register-file write-back port
//   ExLoad/ExWadr             - load in EX and its destination (hazard check)
//   OutReady/OutValid         - downstream handshake
//   OutRdata1/2, OutEd, OutWadr, OutWen, OutOpcode, OutFunct - decoded bundle
//   StallCnt                  - saturating count of hazard-stall cycles

// One register read port: R0 reads zero, a same-cycle write-back wins over
// the stored value.
module id_rd_port #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32
) (
  input  logic [4:0]                  adr_i,
  input  logic [NREG-1:0][DATA_W-1:0] rf_i,
  input  logic                        wb_en_i,
  input  logic [4:0]                  wb_adr_i,
  input  logic [DATA_W-1:0]           wb_data_i,
  output logic [DATA_W-1:0]           data_o
);
  localparam int         AW    = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [5:0] NREG6 = 6'(NREG);

  always_comb begin
    data_o = '0;
    if (adr_i != 5'd0) begin
      if (wb_en_i && (wb_adr_i == adr_i))  data_o = wb_data_i;
      else if ({1'b0, adr_i} < NREG6)      data_o = rf_i[adr_i[AW-1:0]];
    end
  end
endmodule

module id_stage_pipe #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              InValid,
  output logic              InReady,
  input  logic [31:0]       Ins,
  input  logic              Flush,
  input  logic              WbEn,
  input  logic [4:0]        WbAdr,
  input  logic [DATA_W-1:0] WbData,
  input  logic              ExLoad,
  input  logic [4:0]        ExWadr,
  input  logic              OutReady,
  output logic              OutValid,
  output logic [DATA_W-1:0] OutRdata1,
  output logic [DATA_W-1:0] OutRdata2,
  output logic [DATA_W-1:0] OutEd,
  output logic [4:0]        OutWadr,
  output logic              OutWen,
  output logic [5:0]        OutOpcode,
  output logic [5:0]        OutFunct,
  output logic [CNT_W-1:0]  StallCnt
);
  localparam int         AW    = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [5:0] NREG6 = 6'(NREG);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  // Register file
  logic [NREG-1:0][DATA_W-1:0] rf_q;
  logic                        wb_hit;

  assign wb_hit = WbEn && (WbAdr != 5'd0);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) rf_q <= '0;
    else if (wb_hit && ({1'b0, WbAdr} < NREG6)) rf_q[WbAdr[AW-1:0]] <= WbData;
  end

  // Decode fields
  logic [5:0] op, fn;
  logic [4:0] rs, rt;
  assign op = Ins[31:26];
  assign fn = Ins[5:0];
  assign rs = Ins[25:21];
  assign rt = Ins[20:16];

  // Read ports (rs, rt)
  logic [1:0][4:0]        rd_adr;
  logic [1:0][DATA_W-1:0] rd_data;
  assign rd_adr = {rt, rs};

  for (genvar p = 0; p < 2; p++) begin : g_rd
    id_rd_port #(.DATA_W(DATA_W), .NREG(NREG)) u_rd (
      .adr_i    (rd_adr[p]),
      .rf_i     (rf_q),
      .wb_en_i  (WbEn),
      .wb_adr_i (WbAdr),
      .wb_data_i(WbData),
      .data_o   (rd_data[p])
    );
  end

  logic [4:0]        wadr_d;
  logic              wen_d;
  logic [DATA_W-1:0] ed_d;
  logic              rt_used, hazard, adv, capture, stall;

  always_comb begin
    wadr_d = rt;
    if (op == OP_RTYPE)    wadr_d = Ins[15:11];
    else if (op == OP_JAL) wadr_d = 5'd31;

    wen_d = ((op == OP_RTYPE) && (fn != FN_JR)) || (op == OP_JAL) ||
            ((op > OP_BGTZ) && (op != OP_SW));

    // Logical immediates zero-extend; everything else sign-extends
    if ((op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI))
      ed_d = DATA_W'(Ins[15:0]);
    else
      ed_d = DATA_W'($signed(Ins[15:0]));

    rt_used = (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
    hazard  = ExLoad && (ExWadr != 5'd0) &&
              ((ExWadr == rs) || (rt_used && (ExWadr == rt)));
  end

  // Output register
  logic              valid_q;
  logic [DATA_W-1:0] rd1_q, rd2_q, ed_q;
  logic [4:0]        wadr_q, rs_q, rt_q;
  logic              wen_q;
  logic [5:0]        op_q, fn_q;
  logic [CNT_W-1:0]  stall_q;

  assign adv     = !valid_q || OutReady;
  assign InReady = adv && !hazard && !Flush;
  assign capture = InValid && InReady;
  assign stall   = InValid && hazard && adv && !Flush;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      valid_q <= 1'b0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      ed_q    <= '0;
      wadr_q  <= '0;
      wen_q   <= 1'b0;
      op_q    <= '0;
      fn_q    <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
    end else if (Flush) begin
      valid_q <= 1'b0;
    end else if (capture) begin
      valid_q <= 1'b1;
      rd1_q   <= rd_data[0];
      rd2_q   <= rd_data[1];
      ed_q    <= ed_d;
      wadr_q  <= wadr_d;
      wen_q   <= wen_d;
      op_q    <= op;
      fn_q    <= fn;
      rs_q    <= rs;
      rt_q    <= rt;
    end else if (OutReady) begin
      valid_q <= 1'b0;
    end else if (valid_q && wb_hit) begin
      // Held operands track write-backs so EX sees current values on release
      if (WbAdr == rs_q) rd1_q <= WbData;
      if (WbAdr == rt_q) rd2_q <= WbData;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                        stall_q <= '0;
    else if (stall && (stall_q != '1)) stall_q <= stall_q + 1'b1;
  end

  assign OutValid  = valid_q;
  assign OutRdata1 = rd1_q;
  assign OutRdata2 = rd2_q;
  assign OutEd     = ed_q;
  assign OutWadr   = wadr_q;
  assign OutWen    = wen_q;
  assign OutOpcode = op_q;
  assign OutFunct  = fn_q;
  assign StallCnt  = stall_q;
endmodule

// File: doc/id_stage_pipe.md
# id_stage_pipe

Pipelined, parametrised instruction-decode stage for the MIPS core. It holds the architectural register file, decodes the destination register, write enable and immediate extension, and registers the results into an ID/EX pipeline register with a valid/ready handshake. Unlike the single-cycle decoder, writes come from a separate write-back port with same-cycle bypass. The block also stalls on load-use hazards, supports flush, and keeps held operands coherent while the downstream stage is stalled.

## Interface
- DATA_W, 32, register and immediate width (≥16)
- NREG, 32, register count; address width fixed at 5 (NREG ≤ 32)
- CNT_W, 16, width of stall counter

- CLK  in  1  clock, all state on rising edge
- RST  in  1  reset, asynchronous, active-low
- InValid  in  1  Ins is valid
- InReady  out  1  stage accepts Ins this cycle
- Ins  in  32  instruction word
- Flush  in  1  discard pipeline-register contents
- WbEn, WbAdr, WbData  in  1/5/DATA_W  write-back port
- ExLoad, ExWadr  in  1/5  load currently in EX and its destination
- OutReady  in  1  EX accepts output
- OutValid  out  1  output register valid
- OutRdata1, OutRdata2, OutEd  out  DATA_W each  rs value, rt value, extended immediate
- OutWadr  out  5  decoded destination
- OutWen  out  1  decoded write enable
- OutOpcode, OutFunct  out  6 each  passed-through fields
- StallCnt  out  CNT_W  saturating count of hazard-stall cycles

## Operation
- Opcode constants: JAL=0x03, BEQ=0x04, BNE=0x05, BGTZ=0x07, ANDI=0x0C, ORI=0x0D, XORI=0x0E, SW=0x2B, funct JR=0x08.
- Register file: NREG×DATA_W. Register 0 reads as 0 and is never written. A write occurs on the edge when WbEn and WbAdr≠0.
- Read: rs=Ins[25:21], rt=Ins[20:16]. If WbEn and WbAdr equals the read address and the address ≠0, the read returns WbData (bypass). Otherwise it returns the file contents.
- Wadr: opcode 0 → Ins[15:11]; JAL → 31; otherwise Ins[20:16].
- Wen: opcode 0 and funct≠JR; or JAL; or (opcode>BGTZ and opcode≠SW). The JR exclusion applies only when opcode is 0.
- Immediate: opcode ANDI/ORI/XORI → zero-extend Ins[15:0] to DATA_W; all others → sign-extend.
- rt is used as a source only when the opcode is 0, BEQ, BNE or SW.
- Hazard: ExLoad and ExWadr≠0 and (ExWadr==rs, or ExWadr==rt with rt used as a source).
- Flow rules:
  - adv = !OutValid | OutReady.
  - InReady = adv & !hazard & !Flush.
  - Capture when InValid & InReady.
- Output register update:
  - Flush → OutValid←0.
  - Else capture → load all outputs, OutValid←1.
  - Else OutReady → OutValid←0.
  - Otherwise hold.
- Coherency: while holding (OutValid & !OutReady), if WbEn and WbAdr≠0 matches the held rs/rt address, the corresponding OutRdata is updated with WbData. The held addresses are stored internally.
- StallCnt increments each cycle that InValid & hazard & adv & !Flush is true, and saturates at all-ones.

## Timing
- Reset (RST low, async): all registers 0, including the register file, all Out* = 0, OutValid=0, StallCnt=0. InReady is combinational and equals 1 when no hazard or Flush is present.
- Latency: Ins accepted at edge N appears on Out* after edge N, i.e. 1 cycle. Throughput is 1 per cycle while OutReady=1.
- Write-back and a read of the same register in the same cycle: the new value is returned (bypass). The file updates at the same edge.
- Flush and capture in the same cycle: Flush wins, InReady=0, nothing captured.
- Reset mid-stall: outputs clear immediately. The instruction is not retained; upstream must re-present it.
- OutReady=0 with OutValid=1: all Out* stable except the coherency updates to OutRdata.

## Test plan
- Reset, then write R5=0x1234 via WbEn, then present ADD rs=5 rt=0 → next cycle OutRdata1=0x1234, OutRdata2=0, OutWen=1.
- Same-cycle bypass: WbEn R7=0xDEAD while presenting SW rs=7 → OutRdata1=0xDEAD, OutWen=0. Also ORI imm 0x8000 → OutEd=0x00008000, while ADDI imm 0x8000 → OutEd=0xFFFF8000.
- Load-use: ExLoad=1, ExWadr=3, present BEQ rt=3 for 2 cycles → InReady=0, StallCnt=2. Drop ExLoad → captured next edge.
- Backpressure: OutReady=0 holding an instruction with rs=9, WbEn R9=0x55 → OutRdata1 becomes 0x55, and OutValid stays 1.
- Flush with InValid=1 → InReady=0, OutValid=0 next cycle. JR (opcode 0, funct 0x08) → OutWen=0; JAL → OutWadr=31, OutWen=1.
- Assert RST low mid-transfer → all outputs 0 asynchronously. A write to R0 → R0 still reads 0.
